// File: rtl/logistic_sched.sv
`timescale 1ns/1ps
// Logistic-map sweep scheduler: once per ITER_LEN clocks, iterates x <- r*x*(1-x) on every slot
// through one shared req/ack multiplier, writes each iterate as a phase increment, then steps r.
module logistic_sched #(
   parameter int unsigned N_OSC      = 8,
   parameter int unsigned ITER_LEN   = 7681,
   parameter int unsigned R_INC      = 4,
   parameter int unsigned FRAC       = 16,
   parameter int unsigned PHASE_BITS = 16,
   parameter int unsigned FREQ_RES   = 0,
   localparam int unsigned IDX_W     = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic                  mul_req,
   output logic [FRAC+1:0]       mul_a,
   output logic [FRAC+1:0]       mul_b,
   input  logic                  mul_ack,
   input  logic [2*FRAC+3:0]     mul_p,
   output logic                  freq_we,
   output logic [IDX_W-1:0]      freq_idx,
   output logic [PHASE_BITS-1:0] freq_val,
   output logic [FRAC+1:0]       r_out,
   output logic                  busy,
   output logic                  sweep_done,
   output logic                  overrun
);

   localparam int unsigned CNT_W = (ITER_LEN > 1) ? $clog2(ITER_LEN) : 1;

   localparam logic [FRAC+1:0]   R_RESET   = (FRAC+2)'(3) << FRAC;
   localparam logic [FRAC+2:0]   R_LIMIT   = (FRAC+3)'(4) << FRAC;
   localparam logic [FRAC:0]     ONE       = (FRAC+1)'(1) << FRAC;
   localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(N_OSC - 1);
   localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(ITER_LEN - 1);

   // Evenly spaced seeds in (0,1); also used to escape the x = 0 fixed point.
   function automatic logic [FRAC-1:0] seed_of(input int unsigned i);
      logic [FRAC+4:0] num;
      num = (FRAC+5)'(i + 1) << FRAC;
      return FRAC'(num / (FRAC+5)'(N_OSC + 1));
   endfunction

   typedef enum logic [2:0] {
      StIdle,
      StMul1,
      StMul2,
      StWrite,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    slot_q, slot_d;
   logic [FRAC-1:0]     t_q, t_d;
   logic [FRAC-1:0]     xn_q, xn_d;
   logic [FRAC+1:0]     r_q, r_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                overrun_q, overrun_d;
   logic [FRAC-1:0]     x_q [N_OSC];
   logic                x_we;
   logic                start;
   logic [FRAC-1:0]     x_cur;
   logic [FRAC-1:0]     prod_hi;
   logic [FRAC+2:0]     r_sum;
   logic [FRAC-1:0]     seed_tab [N_OSC];

   for (genvar g = 0; g < N_OSC; g++) begin : g_seed
      assign seed_tab[g] = seed_of(g);
   end

   assign x_cur   = x_q[slot_q];
   assign prod_hi = mul_p[2*FRAC-1:FRAC];

   // Only the Q.FRAC slice of the product is meaningful here.
   logic unused_mul_p;
   assign unused_mul_p = ^{mul_p[2*FRAC+3:2*FRAC], mul_p[FRAC-1:0]};

   // Sweep timebase
   always_comb begin
      cnt_d = cnt_q;
      start = enable && (cnt_q == LAST_TICK);
      if (enable) begin
         cnt_d = (cnt_q == LAST_TICK) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      t_d        = t_q;
      xn_d       = xn_q;
      r_d        = r_q;
      overrun_d  = overrun_q;
      x_we       = 1'b0;
      mul_req    = 1'b0;
      mul_a      = '0;
      mul_b      = '0;
      freq_we    = 1'b0;
      freq_idx   = '0;
      freq_val   = '0;
      sweep_done = 1'b0;
      busy       = (state_q != StIdle);
      r_sum      = {1'b0, r_q} + (FRAC+3)'(R_INC);

      if (start && (state_q != StIdle)) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               slot_d  = '0;
               state_d = StMul1;
            end
         end
         StMul1: begin
            mul_req = 1'b1;
            mul_a   = {2'b00, x_cur};
            mul_b   = {1'b0, ONE - {1'b0, x_cur}};
            if (mul_ack) begin
               t_d     = prod_hi;
               state_d = StMul2;
            end
         end
         StMul2: begin
            mul_req = 1'b1;
            mul_a   = r_q;
            mul_b   = {2'b00, t_q};
            if (mul_ack) begin
               xn_d    = (prod_hi == '0) ? seed_tab[slot_q] : prod_hi;
               x_we    = 1'b1;
               state_d = StWrite;
            end
         end
         StWrite: begin
            freq_we  = 1'b1;
            freq_idx = slot_q;
            freq_val = xn_q[FRAC-1 -: PHASE_BITS] >> FREQ_RES;
            if (slot_q < LAST_SLOT) begin
               slot_d  = slot_q + IDX_W'(1);
               state_d = StMul1;
            end else begin
               state_d = StDone;
            end
         end
         StDone: begin
            sweep_done = 1'b1;
            r_d        = (r_sum >= R_LIMIT) ? R_RESET : r_sum[FRAC+1:0];
            state_d    = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         slot_q    <= '0;
         t_q       <= '0;
         xn_q      <= '0;
         r_q       <= R_RESET;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
         for (int unsigned i = 0; i < N_OSC; i++) begin
            x_q[i] <= seed_of(i);
         end
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         t_q       <= t_d;
         xn_q      <= xn_d;
         r_q       <= r_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
         if (x_we) begin
            x_q[slot_q] <= xn_d;
         end
      end
   end

   assign r_out   = r_q;
   assign overrun = overrun_q;

endmodule
